// File: rtl/fan161_arb_pkg.sv
// Shared sizes and state type for the fan161 arbitrated fan-in.
// REG_WIDTH normally comes from the shared defines file; 8 is the fallback.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package fan_pkg;
  localparam int unsigned NUM_FAN_PORTS = 16;
  localparam int unsigned FAN_SEL_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    TURN
  } fan_state_t;
endpackage

// File: rtl/fan161_arb_pick16.sv
// Rotating first-set search over 16 requests, starting at index start.
module fan_pick16
  import fan_pkg::*;
(
  input  logic [NUM_FAN_PORTS-1:0] req,
  input  logic [FAN_SEL_W-1:0]     start,
  output logic [FAN_SEL_W-1:0]     winner,
  output logic                     found
);

  logic [FAN_SEL_W-1:0] idx;

  // Scan from the farthest offset back to the nearest so the closest hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = NUM_FAN_PORTS; i > 0; i--) begin
      idx = start + FAN_SEL_W'(i - 1);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan161_arb.sv
// Sixteen-to-one arbitrated fan-in with hold-time preemption.
// Define FAN161_RR_EN for round-robin; otherwise fixed lowest-index priority.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module fan161_arb
  import fan_pkg::*;
#(
  parameter int unsigned SIGNAL_WIDTH = `REG_WIDTH,
  parameter int unsigned MAX_HOLD     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              req,
  input  logic [SIGNAL_WIDTH-1:0]  in0,
  input  logic [SIGNAL_WIDTH-1:0]  in1,
  input  logic [SIGNAL_WIDTH-1:0]  in2,
  input  logic [SIGNAL_WIDTH-1:0]  in3,
  input  logic [SIGNAL_WIDTH-1:0]  in4,
  input  logic [SIGNAL_WIDTH-1:0]  in5,
  input  logic [SIGNAL_WIDTH-1:0]  in6,
  input  logic [SIGNAL_WIDTH-1:0]  in7,
  input  logic [SIGNAL_WIDTH-1:0]  in8,
  input  logic [SIGNAL_WIDTH-1:0]  in9,
  input  logic [SIGNAL_WIDTH-1:0]  in10,
  input  logic [SIGNAL_WIDTH-1:0]  in11,
  input  logic [SIGNAL_WIDTH-1:0]  in12,
  input  logic [SIGNAL_WIDTH-1:0]  in13,
  input  logic [SIGNAL_WIDTH-1:0]  in14,
  input  logic [SIGNAL_WIDTH-1:0]  in15,
  output logic [15:0]              gnt,
  output logic [3:0]               selector,
  output logic [SIGNAL_WIDTH-1:0]  out,
  output logic                     valid
);

  localparam int unsigned         HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  fan_state_t                     state_q, state_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  logic [NUM_FAN_PORTS-1:0]       gnt_d;
  logic [FAN_SEL_W-1:0]           sel_d;
  logic [SIGNAL_WIDTH-1:0]        out_d;
  logic                           valid_d;
  logic [SIGNAL_WIDTH-1:0]        din [NUM_FAN_PORTS];
  logic [FAN_SEL_W-1:0]           start;
  logic [FAN_SEL_W-1:0]           winner;
  logic                           found;
  logic                           owner_req;
  logic                           others_req;
  logic                           preempt;

  assign din = '{in0, in1, in2, in3, in4, in5, in6, in7,
                 in8, in9, in10, in11, in12, in13, in14, in15};

`ifdef FAN161_RR_EN
  logic [FAN_SEL_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  fan_pick16 u_pick (
    .req    (req),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  assign owner_req  = req[selector];
  assign others_req = |(req & ~(NUM_FAN_PORTS'(1) << selector));
  assign preempt    = (hold_q == HOLD_MAX) && others_req;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    sel_d   = selector;
    out_d   = out;
    valid_d = valid;
`ifdef FAN161_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE, TURN: begin
        valid_d = 1'b0;
        if (found) begin
          state_d = BUSY;
          gnt_d   = NUM_FAN_PORTS'(1) << winner;
          sel_d   = winner;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Preemption is a release; out is only loaded when valid will be set.
        if (!owner_req || preempt) begin
          state_d = TURN;
          gnt_d   = '0;
          valid_d = 1'b0;
`ifdef FAN161_RR_EN
          ptr_d   = selector + 1'b1;
`endif
        end else begin
          out_d   = din[selector];
          valid_d = 1'b1;
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      gnt      <= '0;
      selector <= '0;
      out      <= '0;
      valid    <= 1'b0;
`ifdef FAN161_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gnt      <= gnt_d;
      selector <= sel_d;
      out      <= out_d;
      valid    <= valid_d;
`ifdef FAN161_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fan161_arb.sv
// Randomized bench for fan161_arb against a cycle-level behavioural model.
module tb_fan161_arb;
  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [7:0]  src [16];
  logic [15:0] gnt;
  logic [3:0]  selector;
  logic [7:0]  out;
  logic        valid;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_busy;
  int          m_sel, m_held, m_ptr;
  logic [15:0] m_gnt;
  logic [7:0]  m_out;
  logic        m_valid;

  always #5 clk = ~clk;

  fan161_arb #(.SIGNAL_WIDTH(8), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(src[0]),   .in1(src[1]),   .in2(src[2]),   .in3(src[3]),
    .in4(src[4]),   .in5(src[5]),   .in6(src[6]),   .in7(src[7]),
    .in8(src[8]),   .in9(src[9]),   .in10(src[10]), .in11(src[11]),
    .in12(src[12]), .in13(src[13]), .in14(src[14]), .in15(src[15]),
    .gnt(gnt), .selector(selector), .out(out), .valid(valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int from);
    for (int k = 0; k < 16; k++)
      if (r[(from + k) % 16]) return (from + k) % 16;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 0; m_sel = 0; m_held = 0; m_ptr = 0;
      m_gnt = '0; m_out = '0; m_valid = 1'b0;
    end else if (m_busy) begin
      if (!req[m_sel] || (m_held >= MH - 1 && (req & ~(16'h1 << m_sel)) != 16'h0)) begin
        m_busy = 0; m_gnt = '0; m_valid = 1'b0;
        m_ptr = (m_sel + 1) % 16;
      end else begin
        m_out = src[m_sel]; m_valid = 1'b1; m_held++;
      end
    end else begin
      m_valid = 1'b0;
`ifdef FAN161_RR_EN
      w = pick(req, m_ptr);
`else
      w = pick(req, 0);
`endif
      if (w >= 0) begin
        m_busy = 1; m_sel = w; m_held = 0;
        m_gnt = 16'h1 << w;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("selector", 32'(selector), 32'(m_sel));
    check("out", 32'(out), 32'(m_out));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; req = '0;
    for (int i = 0; i < 16; i++) src[i] = 8'(i * 17);

    // reset state
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    reset = 1'b0;

    // single request from source 3
    req = 16'h0008; src[3] = 8'hA5;
    step();
    check("single_gnt", 32'(gnt), 32'h0008);
    check("single_sel", 32'(selector), 32'd3);
    step();
    check("single_out", 32'(out), 32'hA5);
    check("single_valid", 32'(valid), 32'h1);
    req = 16'h0000;
    step();
    check("release_gnt", 32'(gnt), 32'h0);
    check("release_valid", 32'(valid), 32'h0);
    check("release_out", 32'(out), 32'hA5);
    step();

    // preemption: source 2 holds, source 7 waits
    do_reset();
    req = 16'h0004;
    step();
    req = 16'h0084;
    cnt = 1;
    for (int i = 0; i < 20 && gnt == 16'h0004; i++) begin
      step();
      if (gnt == 16'h0004) cnt++;
    end
    check("preempt_hold", 32'(cnt), 32'(MH));
    check("preempt_turn", 32'(gnt), 32'h0);
    step();
`ifdef FAN161_RR_EN
    check("preempt_next", 32'(gnt), 32'h0080);
`else
    check("preempt_next", 32'(gnt), 32'h0004);
`endif

    // reset in the middle of a grant to source 5
    do_reset();
    req = 16'h0020;
    step();
    step();
    check("mid_valid", 32'(valid), 32'h1);
    reset = 1'b1;
    step();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_out", 32'(out), 32'h0);
    reset = 1'b0;
    step();
    check("mid_regrant", 32'(gnt), 32'h0020);

`ifdef FAN161_RR_EN
    // alternation between sources 0 and 15, each re-raising after release
    do_reset();
    req = 16'h8001;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gnt != 16'h0) begin
        req = req & ~gnt;
        step();
        req = 16'h8001;
      end
    end
`else
    // fixed priority: source 1 regains the bus after its hold limit
    do_reset();
    req = 16'h0006;
    step();
    check("fp_gnt", 32'(gnt), 32'h0002);
    for (int i = 0; i < MH + 1; i++) step();
    check("fp_regrant", 32'(gnt), 32'h0002);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 16; i++) begin
        src[i] = 8'($urandom);
        if ($urandom_range(0, 31) == 0) req[i] = ~req[i];
      end
      if ($urandom_range(0, 63) == 0) req = '0;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
